// File: rtl/fetch_if_id_pkg.sv
// Shared CPU definitions for the fetch stage and the IF/ID register.
// Holds the reset PC, the squash word, instruction width and PC step.
// Also provides the IF/ID record type and a target-alignment helper.
package fetch_if_id_pkg;

    localparam int unsigned  INSTR_W      = 32;
    localparam logic [31:0]  PC_RESET_DEF = 32'h0000_0000;
    localparam logic [31:0]  NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [31:0]  PC_INCR      = 32'd4;

    typedef logic [INSTR_W-1:0] word_t;

    // One IF/ID pipeline slot as seen by decode.
    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t npc;
        logic  valid;
    } if_id_t;

    // Control-transfer targets are word addresses; the low two bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if_id_if.sv
// Fetch-stage bus: instruction-memory port, decode controls and the IF/ID outputs.
// master = fetch stage (drives imem_addr and IF/ID), slave = memory/decode side.
// clk and reset are not part of this bundle; they stay plain module ports.
interface fetch_if_id_if;
    import fetch_if_id_pkg::*;

    logic  LE;
    word_t imem_addr;
    word_t imem_data;
    logic  redirect;
    word_t redirect_target;
    logic  annul;
    logic  flush;
    word_t if_id_instr;
    word_t if_id_pc;
    word_t if_id_npc;
    logic  if_id_valid;
    logic  misalign_err;
    word_t fetch_count;

    modport master (
        input  LE, imem_data, redirect, redirect_target, annul, flush,
        output imem_addr, if_id_instr, if_id_pc, if_id_npc, if_id_valid,
               misalign_err, fetch_count
    );

    modport slave (
        output LE, imem_data, redirect, redirect_target, annul, flush,
        input  imem_addr, if_id_instr, if_id_pc, if_id_npc, if_id_valid,
               misalign_err, fetch_count
    );

endinterface

// File: rtl/fetch_if_id_pc_npc_reg.sv
// PC/nPC register pair: hold on stall, word-aligned jump on redirect, else PC<=nPC, nPC+=4.
// Latency: one cycle from le_i/redirect_i to pc_o/npc_o.
// Backpressure: le_i=0 freezes both registers and ignores redirect_i.
// Ports: clk, reset (sync, active-high), le_i, redirect_i, target_i -> pc_o, npc_o.
module fetch_if_id_pc_npc_reg
    import fetch_if_id_pkg::*;
#(
    parameter word_t PC_RESET = PC_RESET_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  le_i,
    input  logic  redirect_i,
    input  word_t target_i,
    output word_t pc_o,
    output word_t npc_o
);

    word_t pc_q,  pc_d;
    word_t npc_q, npc_d;

    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (le_i) begin
            if (redirect_i) begin
                pc_d  = align_word(target_i);
                npc_d = align_word(target_i) + PC_INCR;
            end else begin
                pc_d  = npc_q;
                npc_d = npc_q + PC_INCR;  // wraps modulo 2^32 by width
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= PC_RESET;
            npc_q <= PC_RESET + PC_INCR;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign pc_o  = pc_q;
    assign npc_o = npc_q;

endmodule

// File: rtl/fetch_if_id.sv
// Instruction fetch + IF/ID register with delay-slot redirect, annul, flush and stall.
// Latency: one cycle from imem_addr to if_id_instr; imem read is combinational.
// Backpressure: LE=0 holds PC/nPC/IF/ID/count; flush still squashes the IF/ID slot.
// Ports: clk, reset (sync, active-high), bus (fetch_if_id_if.master).
module fetch_if_id
    import fetch_if_id_pkg::*;
#(
    parameter word_t PC_RESET = PC_RESET_DEF,
    parameter word_t NOP_WORD = NOP_WORD_DEF
) (
    input  logic           clk,
    input  logic           reset,
    fetch_if_id_if.master  bus
);

    word_t  pc, npc;
    if_id_t if_id_q, if_id_d;
    word_t  count_q, count_d;
    logic   misalign_q, misalign_d;
    logic   squash;

    fetch_if_id_pc_npc_reg #(
        .PC_RESET (PC_RESET)
    ) u_pc_npc (
        .clk        (clk),
        .reset      (reset),
        .le_i       (bus.LE),
        .redirect_i (bus.redirect),
        .target_i   (bus.redirect_target),
        .pc_o       (pc),
        .npc_o      (npc)
    );

    // The word fetched this cycle is dropped on flush, or when it is an annulled delay slot.
    assign squash = bus.flush | (bus.redirect & bus.annul);

    always_comb begin
        if_id_d    = if_id_q;
        count_d    = count_q;
        misalign_d = 1'b0;
        if (bus.LE) begin
            if_id_d.instr = squash ? NOP_WORD : bus.imem_data;
            if_id_d.pc    = pc;
            if_id_d.npc   = npc;
            if_id_d.valid = ~squash;
            if (!squash) begin
                count_d = count_q + 32'd1;
            end
            misalign_d = bus.redirect & (bus.redirect_target[1:0] != 2'b00);
        end else if (bus.flush) begin
            // Stalled flush kills the slot but keeps its pc/npc tags.
            if_id_d.instr = NOP_WORD;
            if_id_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q    <= '{instr: NOP_WORD, pc: '0, npc: '0, valid: 1'b0};
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            if_id_q    <= if_id_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.imem_addr    = pc;
    assign bus.if_id_instr  = if_id_q.instr;
    assign bus.if_id_pc     = if_id_q.pc;
    assign bus.if_id_npc    = if_id_q.npc;
    assign bus.if_id_valid  = if_id_q.valid;
    assign bus.misalign_err = misalign_q;
    assign bus.fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_if_id.sv
// Directed bench for fetch_if_id: each step drives inputs and queues the hand-computed
// post-edge state; a monitor pops one entry after every rising edge and compares.
// Ports: none (top-level bench).
module tb_fetch_if_id;

    logic clk;
    logic reset;

    fetch_if_id_if bus();

    fetch_if_id dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   popped   = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL step%0d %s: got %h expected %h", idx, nm, act, req);
        end
    endtask

    // Monitor: state is sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_addr",    popped, bus.imem_addr,            e.addr);
            chk("if_id_instr",  popped, bus.if_id_instr,          e.instr);
            chk("if_id_pc",     popped, bus.if_id_pc,             e.pc);
            chk("if_id_npc",    popped, bus.if_id_npc,            e.npc);
            chk("if_id_valid",  popped, {31'd0, bus.if_id_valid}, {31'd0, e.valid});
            chk("misalign_err", popped, {31'd0, bus.misalign_err},{31'd0, e.mis});
            chk("fetch_count",  popped, bus.fetch_count,          e.cnt);
            popped++;
        end
    end

    task automatic step(
        input logic rst, input logic le, input logic rd, input logic [31:0] tgt,
        input logic an, input logic fl, input logic [31:0] data,
        input logic [31:0] e_addr, input logic [31:0] e_instr, input logic [31:0] e_pc,
        input logic [31:0] e_npc, input logic e_v, input logic e_m, input logic [31:0] e_cnt);
        exp_t e;
        @(negedge clk);
        reset               = rst;
        bus.LE              = le;
        bus.redirect        = rd;
        bus.redirect_target = tgt;
        bus.annul           = an;
        bus.flush           = fl;
        bus.imem_data       = data;
        e.addr  = e_addr;
        e.instr = e_instr;
        e.pc    = e_pc;
        e.npc   = e_npc;
        e.valid = e_v;
        e.mis   = e_m;
        e.cnt   = e_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        reset               = 1'b1;
        bus.LE              = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
        bus.annul           = 1'b0;
        bus.flush           = 1'b0;
        bus.imem_data       = 32'h0;

        //   rst le rd  target        an fl data          | addr          instr         pc            npc           v  m  cnt
        step(1, 0, 0, 32'h0,        0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);  // 0 reset
        step(0, 1, 0, 32'h0,        0, 0, 32'h8A000001,  32'h4,        32'h8A000001, 32'h0,        32'h4,        1, 0, 1);  // 1
        step(0, 1, 0, 32'h0,        0, 0, 32'h8A000002,  32'h8,        32'h8A000002, 32'h4,        32'h8,        1, 0, 2);  // 2
        step(0, 1, 0, 32'h0,        0, 0, 32'h8A000003,  32'hC,        32'h8A000003, 32'h8,        32'hC,        1, 0, 3);  // 3
        step(0, 1, 0, 32'h0,        0, 0, 32'h11111111,  32'h10,       32'h11111111, 32'hC,        32'h10,       1, 0, 4);  // 4
        step(0, 1, 1, 32'h40,       0, 0, 32'h22222222,  32'h40,       32'h22222222, 32'h10,       32'h14,       1, 0, 5);  // 5 redirect, slot kept
        step(0, 1, 0, 32'h0,        0, 0, 32'h33333333,  32'h44,       32'h33333333, 32'h40,       32'h44,       1, 0, 6);  // 6
        step(0, 1, 1, 32'h80,       1, 0, 32'h44444444,  32'h80,       32'h0,        32'h44,       32'h48,       0, 0, 6);  // 7 annulled slot
        step(0, 0, 1, 32'h100,      0, 0, 32'h55555555,  32'h80,       32'h0,        32'h44,       32'h48,       0, 0, 6);  // 8 stall
        step(0, 0, 1, 32'h100,      0, 0, 32'h55555555,  32'h80,       32'h0,        32'h44,       32'h48,       0, 0, 6);  // 9 stall
        step(0, 1, 1, 32'h100,      0, 0, 32'h55555555,  32'h100,      32'h55555555, 32'h80,       32'h84,       1, 0, 7);  // 10 redirect after stall
        step(0, 1, 1, 32'h43,       0, 0, 32'h66666666,  32'h40,       32'h66666666, 32'h100,      32'h104,      1, 1, 8);  // 11 misaligned
        step(0, 1, 0, 32'h0,        0, 0, 32'h77777777,  32'h44,       32'h77777777, 32'h40,       32'h44,       1, 0, 9);  // 12 pulse ends
        step(0, 0, 0, 32'h0,        0, 1, 32'h12345678,  32'h44,       32'h0,        32'h40,       32'h44,       0, 0, 9);  // 13 stalled flush
        step(0, 1, 0, 32'h0,        0, 1, 32'h88888888,  32'h48,       32'h0,        32'h44,       32'h48,       0, 0, 9);  // 14 flush, PC advances
        step(0, 1, 1, 32'hFFFFFFF8, 0, 0, 32'h99999999,  32'hFFFFFFF8, 32'h99999999, 32'h48,       32'h4C,       1, 0, 10); // 15
        step(0, 1, 0, 32'h0,        0, 0, 32'hAAAAAAAA,  32'hFFFFFFFC, 32'hAAAAAAAA, 32'hFFFFFFF8, 32'hFFFFFFFC, 1, 0, 11); // 16
        step(0, 1, 0, 32'h0,        0, 0, 32'hBBBBBBBB,  32'h0,        32'hBBBBBBBB, 32'hFFFFFFFC, 32'h0,        1, 0, 12); // 17 wrap
        step(1, 1, 1, 32'h201,      0, 0, 32'h0BADF00D,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);  // 18 reset mid-redirect
        step(0, 1, 0, 32'h0,        0, 0, 32'hCCCCCCCC,  32'h4,        32'hCCCCCCCC, 32'h0,        32'h4,        1, 0, 1);  // 19
        step(0, 0, 1, 32'h3,        0, 0, 32'h0,         32'h4,        32'hCCCCCCCC, 32'h0,        32'h4,        1, 0, 1);  // 20 stalled redirect ignored
        step(0, 1, 1, 32'hFFFFFFFD, 0, 0, 32'hDDDDDDDD,  32'hFFFFFFFC, 32'hDDDDDDDD, 32'h4,        32'h8,        1, 1, 2);  // 21 nPC wraps to 0
        step(0, 1, 0, 32'h0,        0, 0, 32'hEEEEEEEE,  32'h0,        32'hEEEEEEEE, 32'hFFFFFFFC, 32'h0,        1, 0, 3);  // 22

        // Let the monitor drain; anything left over is a missed comparison.
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_if_id.md
Name: fetch_if_id

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the SPARC-subset pipeline. Holds PC/nPC and drives the instruction-memory address. Latches the fetched word into the IF/ID register that feeds the decode control unit. Honours SPARC delay-slot semantics on redirects from decode (branch/call/jmpl), plus decode stall (LE) and flush/annul.

Parameters:
PC_RESET, 32'h0000_0000, PC value after reset; nPC resets to PC_RESET+4
NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush/annul (opcode 0x00 decodes as nop)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
LE  in  1  pipeline advance enable; 1 = advance, 0 = stall (hold PC, nPC, IF/ID)
imem_addr  out  32  instruction-memory byte address (= PC, combinational from PC register)
imem_data  in  32  instruction word at imem_addr, combinational read, same cycle
redirect  in  1  decode stage requests a control transfer (target_sel of the instruction in ID)
redirect_target  in  32  byte address of the transfer target
annul  in  1  with redirect: squash the delay-slot instruction
flush  in  1  squash IF/ID contents (insert NOP_WORD) this cycle
if_id_instr  out  32  registered instruction to decode
if_id_pc  out  32  registered PC of if_id_instr
if_id_npc  out  32  registered nPC of if_id_instr (call/jmpl link value source)
if_id_valid  out  1  1 = if_id_instr is a real fetched instruction
misalign_err  out  1  one-cycle pulse: accepted redirect_target had bits[1:0] != 0
fetch_count  out  32  number of instructions written to IF/ID with valid=1

Behaviour:
- Reset (reset=1 at edge, overrides everything): PC=PC_RESET, nPC=PC_RESET+4, if_id_instr=NOP_WORD, if_id_pc=0, if_id_npc=0, if_id_valid=0, misalign_err=0, fetch_count=0.
- All arithmetic is 32-bit and wraps modulo 2^32 (e.g. nPC 32'hFFFF_FFFC + 4 = 0). No error on wrap.
- Priority per edge: reset > LE=0 > redirect > sequential. flush acts only on IF/ID and is evaluated independently of PC/nPC.
- Stall (LE=0, reset=0): PC, nPC, IF/ID, fetch_count hold. redirect/annul are ignored; decode re-presents them when it advances. flush still forces if_id_instr=NOP_WORD, if_id_valid=0; pc/npc fields hold.
- Sequential (LE=1, redirect=0): IF/ID <= {imem_data, PC, nPC}, valid=1. PC<=nPC; nPC<=nPC+4.
- Redirect (LE=1, redirect=1): the word fetched this cycle at PC is the delay slot.
  - IF/ID <= {imem_data, PC, nPC}, valid=1, unless annul=1, in which case IF/ID <= {NOP_WORD, PC, nPC}, valid=0.
  - PC <= {redirect_target[31:2], 2'b00}; nPC <= that value + 4.
- misalign_err: registered. 1 for exactly the cycle after an accepted redirect with redirect_target[1:0] != 0; else 0.
- flush=1 with LE=1: IF/ID loads NOP_WORD with valid=0. PC/nPC still update per redirect/sequential rules, so the fetched word is discarded.
- fetch_count increments by 1 on every edge where IF/ID is written with valid=1; wraps at 2^32.
- Latency: one cycle from imem_addr presentation to if_id_instr.

Decomposition:
- Shared CPU package holds: NOP_WORD, PC_RESET, instruction width (32), PC increment constant (4).
- One natural sub-module: pc_npc_reg (PC/nPC pair with hold/redirect/sequential update and target alignment).
- The IF/ID register and counter stay in the top.

Test Plan:
- Reset then 3 cycles LE=1, imem returns 0x8A000001,0x8A000002,0x8A000003 -> imem_addr 0,4,8; if_id_instr follows one cycle later; if_id_pc 0,4,8; fetch_count=3.
- At PC=0x10, redirect=1, target=0x40, annul=0 -> IF/ID gets the word at 0x10 valid=1; next imem_addr=0x40, then 0x44.
- Same with annul=1 -> if_id_instr=0, valid=0, if_id_pc=0x10; fetch_count not incremented; next imem_addr=0x40.
- LE=0 for 2 cycles with redirect=1 held -> PC, IF/ID, count unchanged; on LE=1 the redirect takes effect.
- redirect_target=0x43 -> next imem_addr=0x40, misalign_err pulses high for one cycle.
- nPC=0xFFFF_FFFC sequential -> PC becomes 0xFFFF_FFFC then 0x0; flush=1 mid-stream -> if_id_valid=0 for that cycle; reset asserted mid-redirect -> all outputs at reset values next cycle.
